// File: rtl/dp_seq_ctrl_pkg.sv
// Shared widths, timing constants and state encoding for the BC-memory datapath sequencer.
package dp_seq_ctrl_pkg;

  localparam int ADDR_W     = 2;
  localparam int DATA_W     = 4;
  localparam int SETTLE_CYC = 3;
  localparam int ACK_TO     = 64;
  localparam int SYNC_STG   = 2;

  localparam int TO_W  = $clog2(ACK_TO);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_REQ_HI,
    ST_REQ_LO,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_RD) || (s == ST_REQ_HI) || (s == ST_REQ_LO) ||
           (s == ST_SETTLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/dp_seq_ctrl_if.sv
// Host and datapath signal bundle for dp_seq_ctrl; master is the sequencer side.
interface dp_seq_ctrl_if;
  import dp_seq_ctrl_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] nwords_m1;
  logic              acc_clr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              dp_en;
  logic [ADDR_W-1:0] dp_ad;
  logic              dp_op;
  logic [DATA_W-1:0] dp_din;
  logic              dp_s;
  // 4-phase handshake: req rises, ack rises, req falls, ack falls; each phase waits on the other side.
  logic              dp_req_a;
  logic              dp_ack_a;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, nwords_m1, acc_clr, wr_req, wr_addr, wr_data, dp_ack_a,
    output wr_ack, dp_en, dp_ad, dp_op, dp_din, dp_s, dp_req_a, busy, done, err
  );

  modport slave (
    output start, nwords_m1, acc_clr, wr_req, wr_addr, wr_data, dp_ack_a,
    input  wr_ack, dp_en, dp_ad, dp_op, dp_din, dp_s, dp_req_a, busy, done, err
  );

endinterface

// File: rtl/dp_seq_ctrl_sync.sv
// Multi-flop synchronizer for the asynchronous datapath acknowledge.
module dp_seq_ctrl_sync #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STG-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STG-2:0], d};
  end

  assign q = chain[STG-1];

endmodule

// File: rtl/dp_seq_ctrl.sv
// Sequencer: services host writes, then walks words 0..N-1 through read, handshake and settle.
module dp_seq_ctrl
  import dp_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  dp_seq_ctrl_if.master bus,
  output state_t        state_dbg
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, nw_q, wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              clr_q, err_q, ack_s, word_s;
  logic [TO_W-1:0]   to_cnt;
  logic [SET_W-1:0]  set_cnt;

  dp_seq_ctrl_sync #(.STG(SYNC_STG)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.dp_ack_a),
    .q     (ack_s)
  );

  assign word_s    = !(clr_q && (idx == '0));
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.wr_req) state_nx = ST_WR;
                 else if (bus.start) state_nx = ST_RD;
      ST_WR:     state_nx = ST_IDLE;
      ST_RD:     state_nx = ST_REQ_HI;
      ST_REQ_HI: if (ack_s) state_nx = ST_REQ_LO;
                 else if (to_cnt == TO_W'(ACK_TO - 1)) state_nx = ST_ERR;
      ST_REQ_LO: if (!ack_s) state_nx = ST_SETTLE;
                 else if (to_cnt == TO_W'(ACK_TO - 1)) state_nx = ST_ERR;
      ST_SETTLE: if (set_cnt == SET_W'(SETTLE_CYC - 1))
                   state_nx = (idx == nw_q) ? ST_DONE : ST_RD;
      ST_DONE:   state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state so a reset drops dp_req_a without waiting for a clock.
  always_comb begin
    bus.wr_ack   = 1'b0;
    bus.dp_en    = 1'b0;
    bus.dp_ad    = '0;
    bus.dp_op    = OP_WRITE;
    bus.dp_din   = '0;
    bus.dp_s     = 1'b0;
    bus.dp_req_a = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = is_busy(state);
    bus.err      = err_q;
    case (state)
      ST_WR: begin
        bus.dp_en  = 1'b1;
        bus.dp_ad  = wa_q;
        bus.dp_din = wd_q;
        bus.wr_ack = 1'b1;
      end
      ST_RD: begin
        bus.dp_en = 1'b1;
        bus.dp_op = OP_READ;
        bus.dp_ad = idx;
        bus.dp_s  = word_s;
      end
      ST_REQ_HI: begin
        bus.dp_req_a = 1'b1;
        bus.dp_ad    = idx;
        bus.dp_s     = word_s;
      end
      ST_REQ_LO, ST_SETTLE: begin
        bus.dp_ad = idx;
        bus.dp_s  = word_s;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      nw_q    <= '0;
      clr_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      to_cnt  <= '0;
      set_cnt <= '0;
    end else begin
      state <= state_nx;
      // Both counters restart on every state change, so each wait gets its own budget.
      to_cnt  <= (state_nx != state) ? '0 : to_cnt + 1'b1;
      set_cnt <= (state_nx != state) ? '0 : set_cnt + 1'b1;
      if (state == ST_IDLE && bus.wr_req) begin
        wa_q <= bus.wr_addr;
        wd_q <= bus.wr_data;
      end
      if (state == ST_IDLE && !bus.wr_req && bus.start) begin
        idx   <= '0;
        nw_q  <= bus.nwords_m1;
        clr_q <= bus.acc_clr;
        err_q <= 1'b0;
      end
      if (state == ST_SETTLE && state_nx == ST_RD) idx <= idx + 1'b1;
      if (state_nx == ST_ERR) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Directed bench for dp_seq_ctrl with a delayed-ack datapath model and a word scoreboard.
module tb_dp_seq_ctrl;
  import dp_seq_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;

  dp_seq_ctrl_if bus ();

  dp_seq_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  int cyc;

  logic [2:0] exp_q[$];
  logic [2:0] cur_exp = '0;

  // Ack model: ack follows req four half-cycle-aligned samples later; ack_en=0 holds it low.
  logic [3:0] hist = '0;
  bit         ack_en = 1'b1;

  always @(negedge clk) begin
    hist = {hist[2:0], bus.dp_req_a};
    bus.dp_ack_a = ack_en ? hist[3] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: every RD is scored against the expected queue; held words are checked until the next RD.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.dp_en && bus.dp_op) begin
        rd_cnt++;
        check("rd_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_exp = exp_q.pop_front();
          check("rd_word", 32'({bus.dp_ad, bus.dp_s}), 32'(cur_exp));
        end
      end else if (state_dbg == ST_REQ_HI || state_dbg == ST_REQ_LO || state_dbg == ST_SETTLE) begin
        check("word_hold", 32'({bus.dp_ad, bus.dp_s}), 32'(cur_exp));
      end
    end
  end

  task automatic wait_done(input int bound);
    int n = 0;
    while (!bus.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic pulse_start(input logic [1:0] nw, input logic clr);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.nwords_m1 = nw;
    bus.acc_clr   = clr;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.nwords_m1 = '0; bus.acc_clr = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.dp_ack_a = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({bus.dp_en, bus.dp_op, bus.dp_s, bus.dp_req_a,
                            bus.busy, bus.done, bus.err, bus.wr_ack}), 32'd0);
    check("rst_ad_din", 32'({bus.dp_ad, bus.dp_din}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Host write
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 4'hA;
    @(negedge clk);
    bus.wr_req = 1'b0;
    check("wr_ctrl", 32'({bus.dp_en, bus.dp_op, bus.wr_ack}), 32'b101);
    check("wr_ad", 32'(bus.dp_ad), 32'd2);
    check("wr_din", 32'(bus.dp_din), 32'hA);
    @(negedge clk);
    check("wr_idle", 32'({bus.wr_ack, bus.dp_en, bus.busy}), 32'd0);
    check("wr_state", 32'(state_dbg), 32'(ST_IDLE));

    // Four-word run with accumulator clear
    busy_cnt = 0; done_cnt = 0; rd_cnt = 0;
    exp_q.push_back({2'd0, 1'b0}); exp_q.push_back({2'd1, 1'b1});
    exp_q.push_back({2'd2, 1'b1}); exp_q.push_back({2'd3, 1'b1});
    pulse_start(2'd3, 1'b1);
    check("run_busy", 32'(bus.busy), 32'd1);
    check("run_rd_state", 32'(state_dbg), 32'(ST_RD));
    wait_done(200);
    @(negedge clk); #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("run_end_busy", 32'(bus.busy), 32'd0);
    check("run_busy_cyc", 32'(busy_cnt), 32'd65);
    check("run_done_cnt", 32'(done_cnt), 32'd1);
    check("run_rd_cnt", 32'(rd_cnt), 32'd4);
    check("run_q_empty", 32'(exp_q.size()), 32'd0);

    // Write and start together: write wins, start dropped
    @(negedge clk);
    bus.wr_req = 1'b1; bus.start = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 4'h5;
    @(negedge clk);
    bus.wr_req = 1'b0; bus.start = 1'b0;
    check("col_wr_ack", 32'(bus.wr_ack), 32'd1);
    check("col_wr_addr_data", 32'({bus.dp_ad, bus.dp_din}), 32'({2'd1, 4'h5}));
    @(negedge clk);
    check("col_no_run", 32'({bus.busy, bus.dp_en}), 32'd0);

    // Start and write while busy are ignored; nwords_m1 is sampled only at start
    done_cnt = 0; rd_cnt = 0;
    exp_q.push_back({2'd0, 1'b1}); exp_q.push_back({2'd1, 1'b1});
    pulse_start(2'd1, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.wr_req = 1'b1; bus.nwords_m1 = 2'd3; bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_req = 1'b0;
    check("busy_no_wr_ack", 32'(bus.wr_ack), 32'd0);
    wait_done(100);
    repeat (3) @(negedge clk);
    #1;
    check("busy_rd_cnt", 32'(rd_cnt), 32'd2);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);

    // Ack timeout
    ack_en = 1'b0;
    exp_q.push_back({2'd0, 1'b0});
    @(negedge clk);
    bus.start = 1'b1; bus.nwords_m1 = 2'd0; bus.acc_clr = 1'b1;
    cyc = 0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("to_cycles", 32'(cyc), 32'd66);
    check("to_err_state", 32'({bus.err, bus.dp_req_a, bus.dp_en}), 32'b100);
    @(negedge clk);
    check("to_after", 32'({bus.err, bus.busy, bus.dp_req_a}), 32'b100);
    check("to_idle", 32'(state_dbg), 32'(ST_IDLE));
    repeat (8) @(negedge clk);
    ack_en = 1'b1;

    // Restart clears err; single word without accumulator clear
    done_cnt = 0;
    exp_q.push_back({2'd0, 1'b1});
    pulse_start(2'd0, 1'b0);
    check("restart_err_clr", 32'(bus.err), 32'd0);
    wait_done(100);
    @(negedge clk); #1;
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    check("single_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while waiting in REQ_HI
    exp_q.push_back({2'd0, 1'b0});
    pulse_start(2'd2, 1'b1);
    repeat (2) @(negedge clk);
    check("arst_pre_req", 32'(bus.dp_req_a), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.dp_req_a), 32'd0);
    check("arst_busy_err", 32'({bus.busy, bus.err}), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_rel_state", 32'(state_dbg), 32'(ST_IDLE));
    check("arst_rel_out", 32'({bus.dp_req_a, bus.busy, bus.dp_en}), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
